// File: rtl/anc_sample_fifo.sv
// Show-ahead sample-triplet FIFO feeding the ANC controller.
// Registered head outputs, sticky overflow flag and saturating drop counter.
module anc_sample_fifo #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 16,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          s_valid,
    input  logic [DW-1:0] s_e,
    input  logic [DW-1:0] s_x,
    input  logic [DW-1:0] s_a,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_e,
    output logic [DW-1:0] m_x,
    output logic [DW-1:0] m_a,
    output logic [AW:0]   level,
    output logic [CW-1:0] drop_cnt,
    output logic          overflow,
    input  logic          ovf_clear
);
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned TW    = 3 * DW;

    logic [TW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr, wptr_n, rptr_n, count_n;
    logic [TW-1:0] s_data, head_n;
    logic          full, pop, push, drop;

    // Handshake decode; flush overrides both push and pop
    always_comb begin
        s_data  = {s_e, s_x, s_a};
        full    = (level == PW'(DEPTH));
        pop     = m_valid & m_ready & ~flush;
        push    = s_valid & ~flush & (~full | pop);
        drop    = s_valid & ~flush & full & ~pop;
        wptr_n  = wptr + PW'(push);
        rptr_n  = rptr + PW'(pop);
        count_n = wptr_n - rptr_n;
        // Bypass when the next head is the entry being written this cycle
        if (push && (rptr_n == wptr)) begin
            head_n = s_data;
        end else begin
            head_n = mem[rptr_n[AW-1:0]];
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= s_data;
        end
    end

    // Pointers, occupancy and registered head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            m_valid <= 1'b0;
            m_e     <= '0;
            m_x     <= '0;
            m_a     <= '0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            m_valid <= 1'b0;
        end else begin
            wptr    <= wptr_n;
            rptr    <= rptr_n;
            level   <= count_n;
            m_valid <= (count_n != '0);
            if (count_n != '0) begin
                {m_e, m_x, m_a} <= head_n;
            end
        end
    end

    // Overflow bookkeeping; a drop in the clear cycle wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (ovf_clear) begin
            overflow <= drop;
            drop_cnt <= CW'(drop);
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != {CW{1'b1}}) begin
                drop_cnt <= drop_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_anc_sample_fifo.sv
// Scoreboard bench for anc_sample_fifo: queue of expected triplets checked on
// every pop, plus an occupancy/counter model checked after every clock.
module tb_anc_sample_fifo;
    localparam int unsigned AW = 3;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;
    localparam int unsigned DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst, flush, s_valid, m_ready, ovf_clear;
    logic [DW-1:0] s_e, s_x, s_a;
    logic          m_valid, overflow;
    logic [DW-1:0] m_e, m_x, m_a;
    logic [AW:0]   level;
    logic [CW-1:0] drop_cnt;

    anc_sample_fifo #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid),
        .s_e(s_e), .s_x(s_x), .s_a(s_a), .m_valid(m_valid), .m_ready(m_ready),
        .m_e(m_e), .m_x(m_x), .m_a(m_a), .level(level), .drop_cnt(drop_cnt),
        .overflow(overflow), .ovf_clear(ovf_clear)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [47:0] sb[$];
    int   mlevel = 0;
    int   mdrop  = 0;
    bit   movf   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock: update the model from the driven inputs, then compare
    task automatic tick();
        bit pop, push, drop;
        pop  = (mlevel != 0) && m_ready && !flush;
        push = s_valid && !flush && ((mlevel < DEPTH) || pop);
        drop = s_valid && !flush && (mlevel == DEPTH) && !pop;
        if (push) sb.push_back({s_e, s_x, s_a});
        if (flush) begin
            sb.delete();
            mlevel = 0;
        end else begin
            mlevel = mlevel + int'(push) - int'(pop);
        end
        if (ovf_clear) begin
            movf  = drop;
            mdrop = drop ? 1 : 0;
        end else if (drop) begin
            movf = 1'b1;
            if (mdrop != 255) mdrop++;
        end
        @(posedge clk);
        #1;
        check("level", 64'(level), 64'(mlevel));
        check("m_valid", 64'(m_valid), 64'(mlevel != 0));
        check("overflow", 64'(overflow), 64'(movf));
        check("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    endtask

    task automatic idle();
        s_valid = 0; m_ready = 0; flush = 0; ovf_clear = 0;
    endtask

    task automatic push_one(input logic [DW-1:0] e);
        s_valid = 1; s_e = e; s_x = ~e; s_a = e * 16'd3;
        tick();
        s_valid = 0;
    endtask

    // Pop-side scoreboard: a handshake seen mid-cycle pops at the next edge
    always @(negedge clk) begin
        if (!rst && !flush && m_valid && m_ready) begin
            if (sb.size() == 0) check("pop_underflow", 64'(1), 64'(0));
            else check("pop_data", 64'({m_e, m_x, m_a}), 64'(sb.pop_front()));
        end
    end

    initial begin
        int sent, c;
        rst = 1; idle(); s_e = 0; s_x = 0; s_a = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_level", 64'(level), 64'(0));
        check("rst_m_e", 64'(m_e), 64'(0));
        check("rst_drop", 64'(drop_cnt), 64'(0));

        // Single sample held while not ready
        s_valid = 1; s_e = 16'h1234; s_x = 16'hFFFE; s_a = 16'h0007;
        tick();
        s_valid = 0;
        check("single_valid", 64'(m_valid), 64'(1));
        check("single_level", 64'(level), 64'(1));
        for (int i = 0; i < 10; i++) begin
            check("single_hold", 64'({m_e, m_x, m_a}), 64'({16'h1234, 16'hFFFE, 16'h0007}));
            tick();
        end
        m_ready = 1; tick(); m_ready = 0;
        check("single_empty", 64'(m_valid), 64'(0));
        tick();

        // Fill past capacity
        for (int i = 1; i <= 10; i++) push_one(16'(i));
        check("fill_level", 64'(level), 64'(8));
        check("fill_ovf", 64'(overflow), 64'(1));
        check("fill_drop", 64'(drop_cnt), 64'(2));
        m_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_valid", 64'(m_valid), 64'(1));
            check("drain_e", 64'(m_e), 64'(i));
            tick();
        end
        m_ready = 0;
        check("drain_empty", 64'(m_valid), 64'(0));
        ovf_clear = 1; tick(); ovf_clear = 0;
        check("clr_drop", 64'(drop_cnt), 64'(0));

        // Push and pop while full
        for (int i = 11; i <= 18; i++) push_one(16'(i));
        s_valid = 1; s_e = 16'd99; s_x = ~16'd99; s_a = 16'd297; m_ready = 1;
        tick();
        s_valid = 0;
        check("full_pp_level", 64'(level), 64'(8));
        check("full_pp_drop", 64'(drop_cnt), 64'(0));
        for (int i = 0; i < 7; i++) tick();
        check("full_pp_last", 64'(m_e), 64'(99));
        tick(); m_ready = 0; tick();

        // Wrap-around with ready outpacing valid
        sent = 0; c = 0;
        while (sent < 200 || mlevel != 0) begin
            s_valid = (sent < 200) && (c % 3 == 0);
            if (s_valid) begin
                s_e = 16'(sent * 7 + 1); s_x = 16'(sent); s_a = 16'(16'hA000 + sent);
                sent++;
            end
            m_ready = (c % 4 != 3);
            tick();
            c++;
            if (c > 2000) begin
                check("wrap_timeout", 64'(c), 64'(0));
                break;
            end
        end
        idle();
        check("wrap_drop", 64'(drop_cnt), 64'(0));
        check("wrap_sb_empty", 64'(sb.size()), 64'(0));

        // Flush with a concurrent push
        for (int i = 0; i < 5; i++) push_one(16'(16'h0500 + i));
        check("flush_pre", 64'(level), 64'(5));
        flush = 1; s_valid = 1; s_e = 16'hDEAD;
        tick();
        flush = 0; s_valid = 0;
        check("flush_level", 64'(level), 64'(0));
        check("flush_valid", 64'(m_valid), 64'(0));
        check("flush_drop", 64'(drop_cnt), 64'(0));
        push_one(16'h0042);
        check("flush_next_valid", 64'(m_valid), 64'(1));
        check("flush_next_e", 64'(m_e), 64'(16'h0042));
        m_ready = 1; tick(); m_ready = 0;

        // Async reset mid-drain
        for (int i = 1; i <= 9; i++) push_one(16'(16'h0900 + i));
        m_ready = 1;
        for (int i = 0; i < 4; i++) tick();
        m_ready = 0;
        check("prerst_level", 64'(level), 64'(4));
        check("prerst_ovf", 64'(overflow), 64'(1));
        #3 rst = 1;
        #1;
        check("arst_valid", 64'(m_valid), 64'(0));
        check("arst_level", 64'(level), 64'(0));
        check("arst_ovf", 64'(overflow), 64'(0));
        check("arst_drop", 64'(drop_cnt), 64'(0));
        sb.delete(); mlevel = 0; mdrop = 0; movf = 0;
        @(posedge clk); #1 rst = 0;
        push_one(16'h0777);
        check("postrst_e", 64'(m_e), 64'(16'h0777));

        // Drop counter saturation and clear-vs-drop priority
        for (int i = 0; i < 7; i++) push_one(16'(i));
        for (int i = 0; i < 300; i++) push_one(16'(16'h3000 + i));
        check("sat_drop", 64'(drop_cnt), 64'(255));
        ovf_clear = 1; s_valid = 1; s_e = 16'hBEEF;
        tick();
        ovf_clear = 0; s_valid = 0;
        check("clr_drop_win_cnt", 64'(drop_cnt), 64'(1));
        check("clr_drop_win_ovf", 64'(overflow), 64'(1));
        ovf_clear = 1; tick(); ovf_clear = 0;
        check("clr_only_ovf", 64'(overflow), 64'(0));
        m_ready = 1;
        for (int i = 0; i < 8; i++) tick();
        idle();
        check("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
